sd_card_cmd_responder: RTL
==========================

SD_CARD_CMD_RESPONDER -- requirements
Module: sd_card_cmd_responder

Interface
REQ-001 SHALL have parameter NCR_BYTES, default 1, meaning response delay in all-ones bytes (legal 1..8).
REQ-002 SHALL have parameter OCR, default 32'h40FF8000, meaning the OCR word returned by CMD58.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; every bit is sampled or driven once per rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port i_cs_n, input, 1 bit: chip select, active low.
REQ-006 SHALL have port i_cmd_in, input, 1 bit: serial command line from the host, MSB first, idle high.
REQ-007 SHALL have port o_sd_response, output, 1 bit: serial response line, MSB first.
REQ-008 SHALL have port o_sd_response_en, output, 1 bit: drive enable for o_sd_response; the line is released when low.
REQ-009 SHALL have port o_cmd_valid, output, 1 bit: one-cycle pulse marking a complete, accepted frame.
REQ-010 SHALL have port o_cmd_index, output, 6 bits: index of the last accepted frame.
REQ-011 SHALL have port o_cmd_arg, output, 32 bits: argument of the last accepted frame.
REQ-012 SHALL have port o_idle, output, 1 bit: card idle-state flag.

Function
REQ-013 Frame format SHALL be 48 bits: start 0, transmission 1, index[5:0], arg[31:0], crc7[6:0], stop 1.
REQ-014 FSM states SHALL be S_IDLE, S_RECV, S_DECODE, S_NCR, S_SEND_R1, S_SEND_OCR.
REQ-015 S_IDLE SHALL move to S_RECV when i_cs_n=0 and i_cmd_in=0; S_RECV SHALL shift the remaining 47 bits.
REQ-016 A transmission bit of 0 or a stop bit of 0 SHALL discard the frame: return to S_IDLE, no response, no o_cmd_valid.
REQ-017 In S_DECODE (one cycle after the stop bit), o_cmd_valid SHALL pulse and o_cmd_index/o_cmd_arg SHALL update and hold until the next accepted frame.
REQ-018 S_NCR SHALL drive 1 with o_sd_response_en=1 for exactly NCR_BYTES*8 cycles, then S_SEND_R1 SHALL shift 8 R1 bits MSB first.
REQ-019 R1 fields: bit7=0, bit6 parameter error, bit3 CRC error, bit2 illegal command, bit0 = o_idle; other bits 0.
REQ-020 Handling by command: CMD0 sets idle; CMD16 with arg != 512 sets the parameter-error bit; CMD17 and CMD24 return R1 only, with no data phase; CMD55 arms an app flag.
REQ-021 CMD41 with the app flag set SHALL clear idle and return R1 with bit0 equal to 0 in that same response; CMD41 without the app flag SHALL be illegal.
REQ-022 The app flag SHALL clear after any frame that follows CMD55.
REQ-023 Any other index SHALL be illegal: R1 with bit2 set and no state change.
REQ-024 For CMD58, after R1, S_SEND_OCR SHALL shift 32 bits MSB first: OCR with bit31 forced to ~o_idle.
REQ-025 After the last response bit, o_sd_response_en SHALL drop to 0 in the next cycle and the FSM SHALL return to S_IDLE.
REQ-026 i_cmd_in SHALL be ignored from S_DECODE until the return to S_IDLE.
REQ-027 i_cs_n=1 in any state SHALL return the FSM to S_IDLE on the next cycle and release the line; idle and the app flag SHALL be kept.
REQ-028 When o_sd_response_en=0, o_sd_response SHALL be 1.

Reset
REQ-029 On i_clk with i_rst_n=0, state SHALL be S_IDLE, o_sd_response=1, o_sd_response_en=0, o_cmd_valid=0, o_cmd_index=0, o_cmd_arg=0, o_idle=1, the app flag cleared and the shift counter cleared.
REQ-030 Reset SHALL take effect mid-frame or mid-response, with outputs at reset values in the cycle after the asserting edge.

Configuration
REQ-031 With SD_RESP_CRC_CHECK_EN defined, CRC7 (x^7+x^3+1, init 0) over the first 40 bits SHALL be compared with the crc7 field.
REQ-032 On CRC mismatch with SD_RESP_CRC_CHECK_EN defined, the response SHALL be R1 with bit3 set, no command action, and o_cmd_valid still pulsed.
REQ-033 Without SD_RESP_CRC_CHECK_EN, crc7 SHALL be ignored, bit3 SHALL always be 0, and no CRC logic SHALL be synthesised.

Verification
REQ-034 CMD0 frame 40 00 00 00 00 95 -> o_cmd_valid pulse with index 0, then 8 ones, then R1=0x01, then en=0.
REQ-035 CMD0 frame 40 00 00 00 00 01 -> R1=0x09 with SD_RESP_CRC_CHECK_EN defined; R1=0x01 without it.
REQ-036 CMD55 then CMD41 (arg 0x40000000) -> R1=0x01, then R1=0x00, o_idle=0; then CMD58 -> R1=0x00 followed by 0xC0FF8000.
REQ-037 CMD41 without a preceding CMD55 -> R1=0x05; CMD8 -> R1=0x05; CMD16 with arg 256 -> R1=0x41.
REQ-038 i_cs_n raised after 20 bits of a CMD17 frame -> no o_cmd_valid, en=0; the next full CMD17 is answered normally.
REQ-039 NCR_BYTES=3 with CMD0 -> exactly 24 ones precede R1; reset asserted during R1 -> en=0 and o_idle=1 next cycle.

Source files
------------

// File: rtl/sd_card_cmd_responder.sv
// sd_card_cmd_responder
// SPI-mode SD card command front end: deserialises 48-bit command frames
// from the host, answers with an R1 byte after an NCR gap, and appends the
// OCR word for CMD58. Tracks the card idle state and the ACMD (CMD55) prefix.
//
// Optional feature: define SD_RESP_CRC_CHECK_EN to verify the CRC7 field of
// each frame. Without the macro the CRC field is ignored and no CRC logic
// is built.
module sd_card_cmd_responder #(
   parameter int unsigned NCR_BYTES = 1,
   parameter logic [31:0] OCR       = 32'h40FF8000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_cs_n,
   input  logic        i_cmd_in,
   output logic        o_sd_response,
   output logic        o_sd_response_en,
   output logic        o_cmd_valid,
   output logic [5:0]  o_cmd_index,
   output logic [31:0] o_cmd_arg,
   output logic        o_idle
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_DECODE,
      S_NCR,
      S_SEND_R1,
      S_SEND_OCR
   } state_t;

   // Terminal counts for the shared bit counter in each phase.
   localparam logic [5:0] RECV_LAST = 6'd46;                  // 47 bits after the start bit
   localparam logic [5:0] NCR_LAST  = 6'(NCR_BYTES * 8 - 1);  // all-ones gap before R1
   localparam logic [5:0] R1_LAST   = 6'd7;
   localparam logic [5:0] OCR_LAST  = 6'd31;

   state_t      state_reg, state_next;
   logic [5:0]  cnt_reg, cnt_next;
   logic [45:0] frame_reg, frame_next;    // received bits after the transmission bit
   logic [46:0] frame_shift;              // frame_reg with the current line bit appended
   logic [39:0] resp_reg, resp_next;      // {R1, OCR} shifted out MSB first
   logic        is_ocr_reg, is_ocr_next;
   logic        valid_reg, valid_next;
   logic [5:0]  index_reg, index_next;
   logic [31:0] arg_reg, arg_next;
   logic        idle_reg, idle_next;
   logic        app_reg, app_next;

   logic        crc_err;
   logic        illegal;
   logic        param_err;
   logic [7:0]  r1_byte;
   logic [31:0] ocr_word;

`ifdef SD_RESP_CRC_CHECK_EN
   // Serial CRC7 (x^7 + x^3 + 1, zero initial value) over the first 40 frame bits.
   function automatic logic [6:0] crc7_calc(input logic [39:0] data);
      logic [6:0] crc;
      logic       fb;
      crc = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb  = data[i] ^ crc[6];
         crc = {crc[5:0], 1'b0};
         if (fb) begin
            crc = crc ^ 7'h09;
         end
      end
      return crc;
   endfunction

   // In S_DECODE the captured index/arg and the received CRC field are all stable.
   assign crc_err = (crc7_calc({2'b01, index_reg, arg_reg}) != frame_reg[7:1]);
`else
   assign crc_err = 1'b0;
`endif

   assign o_cmd_valid = valid_reg;
   assign o_cmd_index = index_reg;
   assign o_cmd_arg   = arg_reg;
   assign o_idle      = idle_reg;

   // Register bank: FSM state, bit counter, frame/response shifters and card flags.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= 6'd0;
         frame_reg  <= '0;
         resp_reg   <= '0;
         is_ocr_reg <= 1'b0;
         valid_reg  <= 1'b0;
         index_reg  <= 6'd0;
         arg_reg    <= 32'd0;
         idle_reg   <= 1'b1;
         app_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         frame_reg  <= frame_next;
         resp_reg   <= resp_next;
         is_ocr_reg <= is_ocr_next;
         valid_reg  <= valid_next;
         index_reg  <= index_next;
         arg_reg    <= arg_next;
         idle_reg   <= idle_next;
         app_reg    <= app_next;
      end
   end

   // Next-state logic, command decode and serial response line drive.
   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      frame_next       = frame_reg;
      resp_next        = resp_reg;
      is_ocr_next      = is_ocr_reg;
      valid_next       = 1'b0;
      index_next       = index_reg;
      arg_next         = arg_reg;
      idle_next        = idle_reg;
      app_next         = app_reg;
      frame_shift      = {frame_reg, i_cmd_in};
      illegal          = 1'b0;
      param_err        = 1'b0;
      r1_byte          = 8'h00;
      ocr_word         = {~idle_reg, OCR[30:0]};
      o_sd_response_en = 1'b0;
      o_sd_response    = 1'b1;

      case (state_reg)
         S_IDLE: begin
            // A low bit while selected is the start bit of a frame.
            if (!i_cmd_in) begin
               state_next = S_RECV;
               cnt_next   = 6'd0;
            end
         end

         S_RECV: begin
            frame_next = frame_shift[45:0];
            cnt_next   = cnt_reg + 6'd1;
            if (cnt_reg == RECV_LAST) begin
               cnt_next = 6'd0;
               // frame_shift[46] is the transmission bit, [0] the stop bit.
               if (frame_shift[46] && frame_shift[0]) begin
                  state_next = S_DECODE;
                  valid_next = 1'b1;
                  index_next = frame_shift[45:40];
                  arg_next   = frame_shift[39:8];
               end else begin
                  state_next = S_IDLE;
               end
            end
         end

         S_DECODE: begin
            // Any decoded frame consumes a pending CMD55 prefix.
            app_next = 1'b0;
            if (!crc_err) begin
               case (index_reg)
                  6'd0:  idle_next = 1'b1;
                  6'd16: param_err = (arg_reg != 32'd512);
                  6'd17, 6'd24, 6'd58: begin
                  end
                  6'd55: app_next = 1'b1;
                  6'd41: begin
                     if (app_reg) begin
                        idle_next = 1'b0;
                     end else begin
                        illegal = 1'b1;
                     end
                  end
                  default: illegal = 1'b1;
               endcase
            end
            // R1 reports the idle flag as it stands after this command.
            r1_byte     = {1'b0, param_err, 2'b00, crc_err, illegal, 1'b0, idle_next};
            is_ocr_next = (index_reg == 6'd58) && !crc_err;
            resp_next   = {r1_byte, ocr_word};
            cnt_next    = 6'd0;
            state_next  = S_NCR;
         end

         S_NCR: begin
            o_sd_response_en = 1'b1;
            o_sd_response    = 1'b1;
            cnt_next         = cnt_reg + 6'd1;
            if (cnt_reg == NCR_LAST) begin
               cnt_next   = 6'd0;
               state_next = S_SEND_R1;
            end
         end

         S_SEND_R1: begin
            o_sd_response_en = 1'b1;
            o_sd_response    = resp_reg[39];
            resp_next        = {resp_reg[38:0], 1'b0};
            cnt_next         = cnt_reg + 6'd1;
            if (cnt_reg == R1_LAST) begin
               cnt_next   = 6'd0;
               state_next = is_ocr_reg ? S_SEND_OCR : S_IDLE;
            end
         end

         S_SEND_OCR: begin
            o_sd_response_en = 1'b1;
            o_sd_response    = resp_reg[39];
            resp_next        = {resp_reg[38:0], 1'b0};
            cnt_next         = cnt_reg + 6'd1;
            if (cnt_reg == OCR_LAST) begin
               cnt_next   = 6'd0;
               state_next = S_IDLE;
            end
         end

         default: begin
            state_next = S_IDLE;
            cnt_next   = 6'd0;
         end
      endcase

      // Deselect aborts whatever is in flight but leaves the card flags untouched.
      if (i_cs_n) begin
         state_next = S_IDLE;
         cnt_next   = 6'd0;
         valid_next = 1'b0;
         index_next = index_reg;
         arg_next   = arg_reg;
         idle_next  = idle_reg;
         app_next   = app_reg;
      end
   end

endmodule
